// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM states,
// default operand width and counter sizing.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count 0..width-1; never narrower than one bit.
    function automatic int cntWidth(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
interface serial_subtractor_if
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_A;
    logic [WIDTH-1:0] io_B;
    logic             io_Bin;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_Diff;
    logic             io_Bout;
    logic             io_busy;

    modport master (
        output io_in_valid, io_A, io_B, io_Bin, io_out_ready,
        input  io_in_ready, io_out_valid, io_Diff, io_Bout, io_busy
    );

    modport slave (
        input  io_in_valid, io_A, io_B, io_Bin, io_out_ready,
        output io_in_ready, io_out_valid, io_Diff, io_Bout, io_busy
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout set when the bit borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B - Bin, one bit per clock LSB first, with
// valid/ready handshakes on the operand and result sides.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    serial_subtractor_if.slave io
);
    localparam int                CNT_W    = cntWidth(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           stateReg, stateNext;
    logic [WIDTH-1:0] aShReg, aShNext;
    logic [WIDTH-1:0] bShReg, bShNext;
    logic [WIDTH-1:0] dShReg, dShNext;
    logic [WIDTH-1:0] diffReg, diffNext;
    logic             borrowReg, borrowNext;
    logic             boutReg, boutNext;
    logic [CNT_W-1:0] cntReg, cntNext;

    logic inReady, outValid, busy;
    logic inFire, outFire;
    logic bitDiff, bitBorrow;

    full_subtractor bitStep (
        .a    (aShReg[0]),
        .b    (bShReg[0]),
        .bin  (borrowReg),
        .diff (bitDiff),
        .bout (bitBorrow)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg  <= IDLE;
            aShReg    <= '0;
            bShReg    <= '0;
            dShReg    <= '0;
            diffReg   <= '0;
            borrowReg <= 1'b0;
            boutReg   <= 1'b0;
            cntReg    <= '0;
        end else begin
            stateReg  <= stateNext;
            aShReg    <= aShNext;
            bShReg    <= bShNext;
            dShReg    <= dShNext;
            diffReg   <= diffNext;
            borrowReg <= borrowNext;
            boutReg   <= boutNext;
            cntReg    <= cntNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        aShNext    = aShReg;
        bShNext    = bShReg;
        dShNext    = dShReg;
        diffNext   = diffReg;
        borrowNext = borrowReg;
        boutNext   = boutReg;
        cntNext    = cntReg;
        inReady    = 1'b0;
        outValid   = 1'b0;
        busy       = 1'b0;
        inFire     = 1'b0;
        outFire    = 1'b0;

        case (stateReg)
            IDLE: inReady = 1'b1;
            RUN:  busy    = 1'b1;
            DONE: begin
                outValid = 1'b1;
                inReady  = io.io_out_ready;
            end
            default: ;
        endcase

        inFire  = io.io_in_valid && inReady;
        outFire = outValid && io.io_out_ready;

        case (stateReg)
            IDLE: begin
                if (inFire) stateNext = RUN;
            end
            RUN: begin
                aShNext    = aShReg >> 1;
                bShNext    = bShReg >> 1;
                dShNext    = {bitDiff, dShReg[WIDTH-1:1]};
                borrowNext = bitBorrow;
                cntNext    = cntReg + CNT_W'(1);
                // Result registers are only touched here, so they hold the
                // last completed result through IDLE and the next RUN.
                if (cntReg == LAST_BIT) begin
                    stateNext = DONE;
                    diffNext  = {bitDiff, dShReg[WIDTH-1:1]};
                    boutNext  = bitBorrow;
                end
            end
            DONE: begin
                if (outFire) stateNext = inFire ? RUN : IDLE;
            end
            default: stateNext = IDLE;
        endcase

        // inFire is only possible in IDLE, or in DONE alongside outFire.
        if (inFire) begin
            aShNext    = io.io_A;
            bShNext    = io.io_B;
            borrowNext = io.io_Bin;
            cntNext    = '0;
        end
    end

    assign io.io_in_ready  = inReady;
    assign io.io_out_valid = outValid;
    assign io.io_busy      = busy;
    assign io.io_Diff      = diffReg;
    assign io.io_Bout      = boutReg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=13: directed
// vectors, backpressure, back-to-back and mid-run reset, then random traffic.
module tb_serial_subtractor;
    import arith_pkg::*;

    localparam int W0    = 8;
    localparam int W1    = 13;
    localparam int NRAND = 1000;

    typedef struct {
        logic [63:0] diff;
        logic        bout;
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   passCnt = 0;
    int   checkCnt = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   prevValid[2];
    bit   prevStall[2];
    bit   prodDone[2];

    serial_subtractor_if #(.WIDTH(W0)) if0 ();
    serial_subtractor_if #(.WIDTH(W1)) if1 ();

    serial_subtractor #(.WIDTH(W0)) dut0 (.clock(clock), .reset(reset), .io(if0));
    serial_subtractor #(.WIDTH(W1)) dut1 (.clock(clock), .reset(reset), .io(if1));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int widthOf(int u);
        return (u == 0) ? W0 : W1;
    endfunction

    function automatic logic [63:0] maskOf(int u);
        return (64'd1 << widthOf(u)) - 64'd1;
    endfunction

    function automatic bit inReady(int u);
        return (u == 0) ? if0.io_in_ready : if1.io_in_ready;
    endfunction
    function automatic bit outValid(int u);
        return (u == 0) ? if0.io_out_valid : if1.io_out_valid;
    endfunction
    function automatic bit outReady(int u);
        return (u == 0) ? if0.io_out_ready : if1.io_out_ready;
    endfunction
    function automatic bit busyOf(int u);
        return (u == 0) ? if0.io_busy : if1.io_busy;
    endfunction
    function automatic bit boutOf(int u);
        return (u == 0) ? if0.io_Bout : if1.io_Bout;
    endfunction
    function automatic logic [63:0] diffOf(int u);
        return (u == 0) ? 64'(if0.io_Diff) : 64'(if1.io_Diff);
    endfunction

    // Reference: plain unsigned arithmetic on the masked operands.
    function automatic exp_t model(int u, logic [63:0] a, logic [63:0] b, bit bin, int due);
        exp_t        e;
        logic [63:0] m;
        logic [64:0] sub;
        logic [64:0] rhs;
        m      = maskOf(u);
        a      = a & m;
        b      = b & m;
        sub    = {1'b0, a} - {1'b0, b} - 65'(bin);
        rhs    = {1'b0, b} + 65'(bin);
        e.diff = sub[63:0] & m;
        e.bout = ({1'b0, a} < rhs);
        e.due  = due;
        return e;
    endfunction

    task automatic check(string name, int u, logic [63:0] act, logic [63:0] req);
        checkCnt++;
        if (act === req) passCnt++;
        else $display("FAIL %s (WIDTH=%0d) cycle %0d: got 0x%0h, expected 0x%0h",
                      name, widthOf(u), cyc, act, req);
    endtask

    task automatic checkBit(string name, int u, bit act, bit req);
        check(name, u, 64'(act), 64'(req));
    endtask

    task automatic pushExp(int u, exp_t e);
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask
    function automatic int qSize(int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction
    function automatic exp_t qFront(int u);
        return (u == 0) ? q0[0] : q1[0];
    endfunction
    task automatic qPop(int u);
        if (u == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask
    task automatic qFlush(int u);
        if (u == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic setIn(int u, bit v, logic [63:0] a, logic [63:0] b, bit bin);
        if (u == 0) begin
            if0.io_in_valid = v; if0.io_A = a[W0-1:0]; if0.io_B = b[W0-1:0]; if0.io_Bin = bin;
        end else begin
            if1.io_in_valid = v; if1.io_A = a[W1-1:0]; if1.io_B = b[W1-1:0]; if1.io_Bin = bin;
        end
    endtask

    task automatic setOutReady(int u, bit r);
        if (u == 0) if0.io_out_ready = r;
        else        if1.io_out_ready = r;
    endtask

    // Offer operands until accepted; the expected result goes on the queue
    // with the cycle at which out_valid must first appear.
    task automatic send(int u, logic [63:0] a, logic [63:0] b, bit bin);
        bit took = 1'b0;
        setIn(u, 1'b1, a, b, bin);
        for (int i = 0; i < 300 && !took; i++) begin
            @(negedge clock);
            if (inReady(u)) begin
                pushExp(u, model(u, a, b, bin, cyc + 1 + widthOf(u)));
                took = 1'b1;
            end
            @(posedge clock); #1;
        end
        if (!took) checkBit("accept_timeout", u, 1'b0, 1'b1);
    endtask

    task automatic waitDrain(int u);
        int n = 0;
        while (qSize(u) != 0 && n < 500) begin
            @(posedge clock); #2;
            n++;
        end
        if (qSize(u) != 0) begin
            check("drain_timeout", u, 64'(qSize(u)), 64'd0);
            qFlush(u);
        end
    endtask

    task automatic waitValid(int u);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!outValid(u) && n < 200);
        if (!outValid(u)) checkBit("valid_timeout", u, 1'b0, 1'b1);
    endtask

    task automatic directed(int u);
        logic [7:0] ta[4] = '{8'h05, 8'h03, 8'h00, 8'hFF};
        logic [7:0] tb[4] = '{8'h03, 8'h05, 8'h00, 8'hFF};
        bit         tc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

        setOutReady(u, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(u, 64'(ta[i]), 64'(tb[i]), tc[i]);
            setIn(u, 1'b0, 64'd0, 64'd0, 1'b0);
            waitDrain(u);
        end

        // Backpressure, with other operands offered while blocked.
        setOutReady(u, 1'b0);
        send(u, 64'h80, 64'h01, 1'b0);
        setIn(u, 1'b1, 64'h3C, 64'h0F, 1'b0);
        waitValid(u);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkBit("bp_in_ready", u, inReady(u), 1'b0);
            checkBit("bp_valid", u, outValid(u), 1'b1);
        end
        @(posedge clock); #1;
        setIn(u, 1'b0, 64'd0, 64'd0, 1'b0);
        setOutReady(u, 1'b1);
        waitDrain(u);
        @(negedge clock);
        checkBit("idle_busy", u, busyOf(u), 1'b0);
        checkBit("idle_valid", u, outValid(u), 1'b0);
        checkBit("idle_in_ready", u, inReady(u), 1'b1);
        @(posedge clock); #1;

        // Back-to-back: second pair accepted on the edge the first result leaves.
        send(u, 64'h10, 64'h01, 1'b0);
        send(u, 64'h01, 64'h10, 1'b0);
        setIn(u, 1'b0, 64'd0, 64'd0, 1'b0);
        waitDrain(u);

        // Reset in the third RUN cycle must clear everything at once.
        send(u, 64'h55, 64'h0F, 1'b0);
        setIn(u, 1'b0, 64'd0, 64'd0, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        checkBit("rst_valid", u, outValid(u), 1'b0);
        checkBit("rst_in_ready", u, inReady(u), 1'b1);
        checkBit("rst_busy", u, busyOf(u), 1'b0);
        check("rst_diff", u, diffOf(u), 64'd0);
        checkBit("rst_bout", u, boutOf(u), 1'b0);
        qFlush(u);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock); #1;
        send(u, 64'h22, 64'h11, 1'b0);
        setIn(u, 1'b0, 64'd0, 64'd0, 1'b0);
        waitDrain(u);
    endtask

    task automatic producer(int u);
        logic [63:0] a;
        logic [63:0] b;
        bit          bin;
        int          gap;
        for (int n = 0; n < NRAND; n++) begin
            a   = {$urandom(), $urandom()};
            b   = {$urandom(), $urandom()};
            bin = 1'($urandom_range(0, 1));
            if ((n % 10) == 0) b = a;
            if ((n % 17) == 0) begin a = 64'd0; b = '1; end
            send(u, a, b, bin);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                setIn(u, 1'b0, 64'd0, 64'd0, 1'b0);
                repeat (gap) begin @(posedge clock); #1; end
            end
        end
        setIn(u, 1'b0, 64'd0, 64'd0, 1'b0);
        waitDrain(u);
        prodDone[u] = 1'b1;
    endtask

    task automatic consumer(int u);
        while (!prodDone[u]) begin
            setOutReady(u, $urandom_range(0, 3) != 0);
            @(posedge clock); #1;
        end
        setOutReady(u, 1'b1);
    endtask

    // Monitor: every cycle a result is presented it must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            for (int u = 0; u < 2; u++) begin
                if (!reset) begin
                    prevValid[u] = 1'b0;
                    prevStall[u] = 1'b0;
                end else begin
                    if (outValid(u)) begin
                        checkBit("busy_in_done", u, busyOf(u), 1'b0);
                        if (!outReady(u)) checkBit("in_ready_stall", u, inReady(u), 1'b0);
                        if (qSize(u) == 0) begin
                            checkBit("spurious_valid", u, 1'b1, 1'b0);
                        end else begin
                            e = qFront(u);
                            if (!prevValid[u]) check("latency", u, 64'(cyc), 64'(e.due));
                            check("diff", u, diffOf(u), e.diff);
                            checkBit("bout", u, boutOf(u), e.bout);
                            if (outReady(u)) qPop(u);
                        end
                    end else if (prevStall[u]) begin
                        checkBit("hold_valid", u, 1'b0, 1'b1);
                    end
                    if (busyOf(u)) checkBit("in_ready_busy", u, inReady(u), 1'b0);
                    prevValid[u] = outValid(u);
                    prevStall[u] = outValid(u) && !outReady(u);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        setIn(0, 1'b0, 64'd0, 64'd0, 1'b0);
        setIn(1, 1'b0, 64'd0, 64'd0, 1'b0);
        setOutReady(0, 1'b0);
        setOutReady(1, 1'b0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        for (int u = 0; u < 2; u++) begin
            checkBit("reset_in_ready", u, inReady(u), 1'b1);
            checkBit("reset_valid", u, outValid(u), 1'b0);
            checkBit("reset_busy", u, busyOf(u), 1'b0);
            check("reset_diff", u, diffOf(u), 64'd0);
            checkBit("reset_bout", u, boutOf(u), 1'b0);
        end
        #3 reset = 1'b1;
        @(posedge clock); #1;

        directed(0);
        directed(1);

        fork
            producer(0);
            consumer(0);
            producer(1);
            consumer(1);
        join

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor computing io_A - io_B - io_Bin over WIDTH cycles, LSB first, one full-subtractor evaluation per cycle.
- Complements the combinational ripple-carry adder in the arithmetic examples set: trades area for latency.
- Valid/ready handshake on both the operand side and the result side, so it drops into streaming datapaths and testers.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; asserting (0) clears all state immediately; deassertion is synchronised externally.
- io_in_valid  input  1  operands io_A/io_B/io_Bin valid this cycle.
- io_in_ready  output  1  block can accept operands this cycle.
- io_A  input  WIDTH  minuend.
- io_B  input  WIDTH  subtrahend.
- io_Bin  input  1  borrow-in.
- io_out_valid  output  1  io_Diff/io_Bout hold a completed result.
- io_out_ready  input  1  consumer takes result this cycle.
- io_Diff  output  WIDTH  difference (A - B - Bin) mod 2^WIDTH.
- io_Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned).
- io_busy  output  1  high in RUN state.

Behaviour:
- Reset values: state=IDLE, io_in_ready=1, io_out_valid=0, io_busy=0, io_Diff=0, io_Bout=0, bit counter=0, all shift registers=0.
- Internal registers:
  - a_sh, b_sh: WIDTH-bit operand shift registers.
  - d_sh: WIDTH-bit result shift register.
  - borrow: 1 bit.
  - cnt: clog2(WIDTH) bits.
- Input transfer occurs on a cycle where io_in_valid && io_in_ready. Output transfer occurs on a cycle where io_out_valid && io_out_ready.
- IDLE state:
  - io_in_ready=1.
  - On input transfer: a_sh<=io_A, b_sh<=io_B, borrow<=io_Bin, cnt<=0, next state RUN.
- RUN state (io_in_ready=0, io_busy=1), per cycle:
  - d = a_sh[0]^b_sh[0]^borrow.
  - borrow <= (~a_sh[0]&b_sh[0]) | (~a_sh[0]&borrow) | (b_sh[0]&borrow).
  - a_sh, b_sh shift right by 1.
  - d_sh <= {d, d_sh[WIDTH-1:1]}.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1, this last bit is processed and the next state is DONE.
- DONE state:
  - io_out_valid=1, io_Diff=d_sh, io_Bout=borrow.
  - All outputs are held stable while io_out_ready=0, for any number of cycles.
  - io_in_ready = io_out_ready, so a new input may be accepted in the same cycle the result is taken.
  - Output transfer with no input transfer: next state IDLE.
  - Output transfer and input transfer in the same cycle: load the new operands, next state RUN directly.
- io_in_valid in RUN, or in DONE with io_out_ready=0, is ignored; the producer must hold its operands.
- Latency: input transfer at edge N; io_out_valid high from edge N+WIDTH. Sustained throughput is one result per WIDTH+1 cycles.
- io_Diff and io_Bout are driven only from registers; there is no combinational path from inputs to outputs.
- io_Diff and io_Bout retain their last DONE value in IDLE/RUN. They are meaningful only while io_out_valid=1.
- Reset asserted mid-RUN or mid-DONE aborts the operation: all registers return to reset values asynchronously, and no partial result is ever presented.
- Unsigned arithmetic only; signed overflow is not reported.

Decomposition:
- Shared package arith_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the default WIDTH constant;
  - a function returning the counter width, clog2(WIDTH).
- One sub-module, full_subtractor (combinational, ports a, b, bin, diff, bout), instantiated once for the per-bit step.

Test Plan:
- A=0x05, B=0x03, Bin=0, out_ready=1 -> out_valid exactly 8 cycles after accept; Diff=0x02, Bout=0.
- A=0x03, B=0x05, Bin=0 -> Diff=0xFE, Bout=1; A=0x00, B=0x00, Bin=1 -> Diff=0xFF, Bout=1; A=0xFF, B=0xFF, Bin=0 -> Diff=0x00, Bout=0.
- Backpressure: A=0x80, B=0x01, out_ready=0 for 5 cycles after out_valid -> Diff=0x7F, Bout=0 stable all 5 cycles; in_ready=0 throughout; state leaves DONE only when out_ready=1.
- Back-to-back: in_valid and out_ready held high with operand pairs (0x10,0x01) then (0x01,0x10) -> results 0x0F/Bout=0 then 0xF1/Bout=1, spaced exactly 9 cycles apart.
- Reset mid-RUN: reset=0 at cycle 3 of RUN -> out_valid=0, in_ready=1, busy=0 immediately (asynchronous). After release, A=0x22, B=0x11 -> Diff=0x11 with no trace of the aborted operation.
- Randomised cross-check of 1000 operand triples against a reference model (A-B-Bin) for WIDTH=8 and WIDTH=13, with random in_valid/out_ready gaps.
